// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction memory byte writes out.
// master = loader side, slave = source/memory side.
interface imem_loader_if #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte image into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, LOAD, CHECK, DONE, ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHECK;
`else
  localparam state_t FIN = DONE;
`endif

  state_t      state, state_n;
  logic [AW:0] cnt, len;
  logic [7:0]  len_lo;
  logic [16:0] len_in;
  logic        xfer, wr, last, idle_st;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign idle_st = (state == IDLE) || (state == DONE) || (state == ERR);
  assign busy    = (state == LEN_LO) || (state == LEN_HI)
                || (state == LOAD)   || (state == CHECK);
  assign bus.rx_ready = busy;
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);

  assign xfer   = bus.rx_valid & bus.rx_ready;
  assign len_in = {1'b0, bus.rx_data, len_lo};
  assign last   = (cnt + 1'b1) == len;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr      = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_n = LEN_LO;
      LEN_LO: if (xfer) state_n = LEN_HI;
      LEN_HI: if (xfer) begin
        if (len_in == 17'd0)              state_n = FIN;
        else if (len_in > 17'(DEPTH))     state_n = ERR;
        else                              state_n = LOAD;
      end
      LOAD: if (xfer) begin
        wr = 1'b1;
        if (last) state_n = FIN;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (xfer) begin
        state_n = (csum == bus.rx_data) ? DONE : ERR;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      len           <= '0;
      len_lo        <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= wr;
      if (idle_st && start) cnt <= '0;
      if (state == LEN_LO && xfer) len_lo <= bus.rx_data;
      if (state == LEN_HI && xfer) len <= len_in[AW:0];
      if (wr) begin
        bus.mem_addr  <= cnt[AW-1:0];
        bus.mem_wdata <= WIDTH'(bus.rx_data);
        cnt           <= cnt + 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // running XOR over payload bytes only
  always_ff @(posedge clk) begin
    if (rst)                 csum <= '0;
    else if (idle_st && start) csum <= '0;
    else if (wr)             csum <= csum ^ bus.rx_data;
  end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// Expected writes queued at drive time, popped on mem_we.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst, start;
  logic cpu_hold, busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int wr0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        e;
  logic [7:0] pay[$];
  logic [7:0] mem[256];

  always #5 clk = ~clk;

  imem_loader_if #(.DEPTH(256), .WIDTH(8)) bus ();

  imem_loader #(.DEPTH(256), .WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      n_wr++;
      mem[bus.mem_addr] = bus.mem_wdata;
      if (exp_q.size() == 0) begin
        check("wr_unexp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    @(negedge clk);
    if (gap) begin
      bus.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_len(input logic [15:0] l, input bit gap);
    send(l[7:0], gap);
    send(l[15:8], gap);
  endtask

  task automatic send_pay(input bit gap);
    foreach (pay[i]) begin
      exp_q.push_back({8'(i), pay[i]});
      send(pay[i], gap);
    end
  endtask

  task automatic send_csum(input bit bad);
    logic [7:0] x;
    x = 8'h00;
    foreach (pay[i]) x = x ^ pay[i];
    if (bad) x = x ^ 8'h01;
    send(x, 1'b0);
  endtask

  task automatic load(input bit gap);
    send_len(16'(pay.size()), gap);
    send_pay(gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_csum(1'b0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_rx();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    check({p, "_rdy"},   32'(bus.rx_ready), 32'd0);
    check({p, "_we"},    32'(bus.mem_we), 32'd0);
    check({p, "_addr"},  32'(bus.mem_addr), 32'd0);
    check({p, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({p, "_hold"},  32'(cpu_hold), 32'd1);
    check({p, "_busy"},  32'(busy), 32'd0);
    check({p, "_done"},  32'(done), 32'd0);
    check({p, "_err"},   32'(error), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    // basic 4-byte image
    pay = '{8'hF0, 8'h0A, 8'h10, 8'h20};
    wr0 = n_wr;
    pulse_start();
    check("busy_len", 32'(busy), 32'd1);
    load(1'b0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("b_done", 32'(done), 32'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("b_last_we", 32'(bus.mem_we), 32'd1);
`endif
    repeat (3) @(negedge clk);
    check("b_hold", 32'(cpu_hold), 32'd0);
    check("b_busy", 32'(busy), 32'd0);
    check("b_nwr", 32'(n_wr - wr0), 32'd4);
    check("b_word0", {mem[3], mem[2], mem[1], mem[0]}, 32'h20100AF0);

    // over-length image rejected
    wr0 = n_wr;
    pulse_start();
    check("o_done_clr", 32'(done), 32'd0);
    send_len(16'h0101, 1'b0);
    idle_rx();
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("o_err", 32'(error), 32'd1);
    check("o_rdy", 32'(bus.rx_ready), 32'd0);
    check("o_hold", 32'(cpu_hold), 32'd1);
    check("o_nwr", 32'(n_wr - wr0), 32'd0);

    // full-depth image, valid toggling
    pay.delete();
    for (int k = 0; k < 256; k++) pay.push_back(8'((k * 7 + 3) ^ 8'h5A));
    wr0 = n_wr;
    pulse_start();
    check("f_err_clr", 32'(error), 32'd0);
    load(1'b1);
    idle_rx();
    repeat (3) @(negedge clk);
    check("f_done", 32'(done), 32'd1);
    check("f_nwr", 32'(n_wr - wr0), 32'd256);
    check("f_q", 32'(exp_q.size()), 32'd0);

    // reset mid-session, coinciding with a transfer
    pulse_start();
    send_len(16'd4, 1'b0);
    exp_q.push_back({8'd0, 8'h11});
    send(8'h11, 1'b0);
    exp_q.push_back({8'd1, 8'h22});
    send(8'h22, 1'b0);
    @(negedge clk);
    bus.rx_data = 8'h33;
    rst = 1'b1;
    @(negedge clk);
    chk_reset("mid");
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("mid_q", 32'(exp_q.size()), 32'd0);
    pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    wr0 = n_wr;
    pulse_start();
    load(1'b0);
    idle_rx();
    repeat (3) @(negedge clk);
    check("r_done", 32'(done), 32'd1);
    check("r_nwr", 32'(n_wr - wr0), 32'd4);

    // zero-length image
    pay.delete();
    wr0 = n_wr;
    pulse_start();
    send_len(16'd0, 1'b0);
    idle_rx();
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("z_wait", 32'(done), 32'd0);
    send_csum(1'b0);
    idle_rx();
    @(negedge clk);
`endif
    check("z_done", 32'(done), 32'd1);
    check("z_nwr", 32'(n_wr - wr0), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay = '{8'h12, 8'h34};
    pulse_start();
    send_len(16'd2, 1'b0);
    send_pay(1'b0);
    send_csum(1'b0);
    idle_rx();
    @(negedge clk);
    check("c_ok_done", 32'(done), 32'd1);
    pulse_start();
    send_len(16'd2, 1'b0);
    send_pay(1'b0);
    send_csum(1'b1);
    idle_rx();
    @(negedge clk);
    check("c_bad_err", 32'(error), 32'd1);
    check("c_bad_hold", 32'(cpu_hold), 32'd1);
    check("c_bad_done", 32'(done), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("end_q", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, memory size in bytes; AW = ceil(log2(DEPTH)).
REQ-002 Parameter WIDTH, default 8, memory word (byte) width; fixed at 8 for this block.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a load session.
REQ-006 rx_valid  in  1  incoming byte valid.
REQ-007 rx_data  in  8  incoming byte.
REQ-008 rx_ready  out  1  loader accepts rx_data when high; transfer = rx_valid & rx_ready at a rising edge.
REQ-009 mem_we  out  1  byte write strobe to instruction memory.
REQ-010 mem_addr  out  AW  byte write address.
REQ-011 mem_wdata  out  WIDTH  byte write data.
REQ-012 cpu_hold  out  1  holds the CPU in reset while high.
REQ-013 busy  out  1  session in progress.
REQ-014 done  out  1  image loaded successfully; sticky.
REQ-015 error  out  1  session aborted; sticky.

Function
REQ-016 FSM states: IDLE, LEN_LO, LEN_HI, LOAD, CHECK, DONE, ERR.
REQ-017 Frame: length L as 16-bit little-endian (low byte first), then L payload bytes, then one checksum byte if CHECKSUM_EN.
REQ-018 start moves IDLE/DONE/ERR to LEN_LO, clears done, error and the byte counter; start is ignored in every other state.
REQ-019 rx_ready = 1 only in LEN_LO, LEN_HI, LOAD and CHECK; 0 otherwise.
REQ-020 LEN_LO -> LEN_HI on transfer; LEN_HI -> LOAD on transfer if 1 <= L <= DEPTH.
REQ-021 LEN_HI: L = 0 goes to DONE, or to CHECK if CHECKSUM_EN; L > DEPTH goes to ERR.
REQ-022 Payload byte k (k = 0..L-1) is written to address k: mem_we = 1, mem_addr = k, mem_wdata = byte, registered, in the cycle after its transfer.
REQ-023 mem_we is exactly one cycle per payload byte and 0 for length/checksum bytes.
REQ-024 Word assembly is little-endian by byte address: the byte at address 4n is bits [7:0] of word n.
REQ-025 Byte counter is AW+1 bits wide, so L = DEPTH is legal and no address wraps.
REQ-026 After transfer of byte L-1, LOAD -> DONE (no CHECKSUM_EN); done rises in the cycle after, together with the last mem_we.
REQ-027 A gap in rx_valid stalls the FSM with no write and no state change.
REQ-028 busy = 1 in LEN_LO, LEN_HI, LOAD and CHECK.
REQ-029 cpu_hold = 1 in every state except DONE.
REQ-030 ERR: rx_ready = 0, error = 1, cpu_hold = 1; leaves only via start or rst.

Reset
REQ-031 rst at any cycle, including mid-session, forces IDLE on the next edge.
REQ-032 Reset values: rx_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 1, busy = 0, done = 0, error = 0, counter = 0.
REQ-033 No mem_we is issued in the cycle after an rst edge, even if a transfer coincided with it.

Configuration
REQ-034 Macro IMEM_LOADER_CHECKSUM_EN: when defined, the CHECK state exists and accepts one byte after the payload.
REQ-035 With IMEM_LOADER_CHECKSUM_EN, the running XOR of all payload bytes (initial 0x00, length bytes excluded) is compared to the checksum byte: equal -> DONE, unequal -> ERR.
REQ-036 Without IMEM_LOADER_CHECKSUM_EN, CHECK and the XOR logic are absent; LOAD goes directly to DONE.

Verification
REQ-037 Reset, then start, then stream 04 00 F0 0A 10 20 -> writes addr 0..3 = F0,0A,10,20 in order; done=1; cpu_hold=0; word 0 reads 0x20100AF0.
REQ-038 Length 01 01 (257) with DEPTH=256 -> error=1, rx_ready=0, no mem_we, cpu_hold stays 1.
REQ-039 Length 00 01 (256), 256 bytes with rx_valid toggling every other cycle -> exactly 256 writes to addresses 0x00..0xFF; done=1.
REQ-040 rst asserted after the 2nd of 4 payload bytes -> IDLE next cycle, all outputs at reset values; a fresh start plus full frame then completes normally.
REQ-041 CHECKSUM_EN: payload 12 34 with checksum 26 -> done; checksum 27 -> error, cpu_hold=1.
REQ-042 Length 00 00 -> no writes; done=1 (no CHECKSUM_EN), or done only after checksum byte 00 (CHECKSUM_EN).
